// File: rtl/hexdump_streamer.sv
// hexdump_streamer: reads a word range from a 1-cycle-latency buffer RAM and
// emits each word as readmemh-style text (8 lowercase hex digits + LF) over a
// valid/ready byte stream.
module hexdump_streamer #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_cnt,
    output logic              busy,
    output logic              done,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_radr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_REQ   = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_SEND_HEX = 3'd3,
        S_SEND_NL  = 3'd4,
        S_FIN      = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [2:0]          nib_q, nib_d;

    logic                hs;
    logic [3:0]          nib_val;
    logic [7:0]          hex_char;

    // ASCII encoding of the leading nibble (lowercase a-f)
    always_comb begin
        nib_val  = shreg_q[DATA_W-1 -: 4];
        hex_char = (nib_val < 4'd10) ? (8'h30 + {4'h0, nib_val})
                                     : (8'h57 + {4'h0, nib_val});
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            shreg_q <= '0;
            nib_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            shreg_q <= shreg_d;
            nib_q   <= nib_d;
        end
    end

    // Next-state logic and Moore outputs
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        shreg_d  = shreg_q;
        nib_d    = nib_q;
        busy     = (state_q != S_IDLE);
        done     = 1'b0;
        ram_re   = 1'b0;
        ram_radr = addr_q;
        tx_valid = 1'b0;
        tx_data  = '0;
        hs       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = word_cnt;
                    state_d = (word_cnt == '0) ? S_FIN : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                ram_re  = 1'b1;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                shreg_d = ram_rdata;
                nib_d   = 3'd7;
                state_d = S_SEND_HEX;
            end
            S_SEND_HEX: begin
                tx_valid = 1'b1;
                tx_data  = hex_char;
                hs       = tx_ready;
                if (hs) begin
                    shreg_d = {shreg_q[DATA_W-5:0], 4'h0};
                    nib_d   = nib_q - 3'd1;
                    if (nib_q == 3'd0) begin
                        state_d = S_SEND_NL;
                    end
                end
            end
            S_SEND_NL: begin
                tx_valid = 1'b1;
                tx_data  = 8'h0A;
                hs       = tx_ready;
                if (hs) begin
                    addr_d  = addr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == {{ADDR_W{1'b0}}, 1'b1}) ? S_FIN : S_RD_REQ;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // abort wins over everything, including a handshake this cycle
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

endmodule

// File: tb/tb_hexdump_streamer.sv
// Directed self-checking bench for hexdump_streamer.
module tb_hexdump_streamer;

    localparam int unsigned ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   word_cnt = '0;
    logic              busy, done, ram_re, tx_valid;
    logic [ADDR_W-1:0] ram_radr;
    logic [31:0]       ram_rdata = '0;
    logic [7:0]        tx_data;
    logic              tx_ready = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [0:511];
    logic [7:0]  rx [$];
    int          rd [$];
    int          done_cnt = 0;
    int          valid_seen = 0;
    int          stab_err = 0;
    int          ready_mode = 0;
    int          rcnt = 0;

    logic        prev_v = 1'b0, prev_r = 1'b0, prev_ab = 1'b0;
    logic [7:0]  prev_d = '0;

    hexdump_streamer #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .word_cnt(word_cnt), .busy(busy), .done(done),
        .ram_re(ram_re), .ram_radr(ram_radr), .ram_rdata(ram_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    // 1-cycle-latency RAM model
    always @(posedge clk) if (ram_re) ram_rdata <= mem[ram_radr];

    // Sink readiness: always ready, or ready one cycle in three
    always @(posedge clk) begin
        #2;
        rcnt++;
        tx_ready = (ready_mode == 0) ? 1'b1 : ((rcnt % 3) == 0);
    end

    // Monitor at the inactive edge: handshakes, reads, done, stability
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0; prev_r = 1'b0; prev_ab = 1'b0;
        end else begin
            if (prev_v && !prev_r && !prev_ab && (!tx_valid || tx_data !== prev_d)) stab_err++;
            if (tx_valid) valid_seen++;
            if (tx_valid && tx_ready) rx.push_back(tx_data);
            if (ram_re) rd.push_back(int'(ram_radr));
            if (done) done_cnt++;
            prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data; prev_ab = abort;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        rx.delete(); rd.delete();
        done_cnt = 0; valid_seen = 0; stab_err = 0;
    endtask

    task automatic do_start(input int b, input int c);
        base_addr = ADDR_W'(b);
        word_cnt  = (ADDR_W+1)'(c);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts cycles (the cycle after the start edge is 1) until done is seen
    task automatic wait_done(output int cyc, input int limit);
        cyc = 1;
        while (cyc <= limit) begin
            @(negedge clk);
            if (done) begin
                tick();
                return;
            end
            tick();
            cyc++;
        end
        cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (ram_re !== 1'b0)   begin n_bad++; $display("FAIL reset_ram_re got %b want 0", ram_re); end
        n_cmp++; if (ram_radr !== '0)   begin n_bad++; $display("FAIL reset_radr got %h want 000", ram_radr); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        string exp = "1234abcd\n";
        int cyc;
        mem[9'h010] = 32'h1234ABCD;
        ready_mode = 0;
        clear_mon();
        do_start(9'h010, 1);
        wait_done(cyc, 40);
        n_cmp++; if (cyc !== 12) begin n_bad++; $display("FAIL single_latency got %0d want 12", cyc); end
        n_cmp++; if (rx.size() !== exp.len()) begin n_bad++; $display("FAIL single_len got %0d want %0d", rx.size(), exp.len()); end
        for (int i = 0; i < exp.len() && i < rx.size(); i++) begin
            n_cmp++; if (rx[i] !== exp[i]) begin n_bad++; $display("FAIL single_byte%0d got %h want %h", i, rx[i], exp[i]); end
        end
        n_cmp++; if (rd.size() !== 1) begin n_bad++; $display("FAIL single_reads got %0d want 1", rd.size()); end
        if (rd.size() > 0) begin
            n_cmp++; if (rd[0] !== 'h010) begin n_bad++; $display("FAIL single_radr got %h want 010", rd[0]); end
        end
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_after got done=%b busy=%b want 0 0", done, busy); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL single_done_cnt got %0d want 1", done_cnt); end
    endtask

    task automatic test_wrap();
        string exp = "00000000\nffffffff\n";
        int cyc;
        mem[9'h1FF] = 32'h00000000;
        mem[9'h000] = 32'hFFFFFFFF;
        clear_mon();
        do_start(9'h1FF, 2);
        wait_done(cyc, 60);
        n_cmp++; if (cyc !== 23) begin n_bad++; $display("FAIL wrap_latency got %0d want 23", cyc); end
        n_cmp++; if (rx.size() !== exp.len()) begin n_bad++; $display("FAIL wrap_len got %0d want %0d", rx.size(), exp.len()); end
        for (int i = 0; i < exp.len() && i < rx.size(); i++) begin
            n_cmp++; if (rx[i] !== exp[i]) begin n_bad++; $display("FAIL wrap_byte%0d got %h want %h", i, rx[i], exp[i]); end
        end
        n_cmp++; if (rd.size() !== 2) begin n_bad++; $display("FAIL wrap_reads got %0d want 2", rd.size()); end
        if (rd.size() == 2) begin
            n_cmp++; if (rd[0] !== 'h1FF || rd[1] !== 'h000) begin n_bad++; $display("FAIL wrap_radr got %h,%h want 1ff,000", rd[0], rd[1]); end
        end
    endtask

    task automatic test_zero_count();
        int cyc;
        clear_mon();
        do_start(9'h0AA, 0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL zero_busy1 got %b want 1", busy); end
        wait_done(cyc, 10);
        n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL zero_latency got %0d want 1", cyc); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy2 got %b want 0", busy); end
        n_cmp++; if (rd.size() !== 0 || valid_seen !== 0) begin n_bad++; $display("FAIL zero_activity got reads=%0d valids=%0d want 0 0", rd.size(), valid_seen); end
    endtask

    task automatic test_backpressure();
        string exp = "9f00e001\n";
        int cyc;
        mem[9'h005] = 32'h9F00E001;
        ready_mode = 1;
        clear_mon();
        do_start(9'h005, 1);
        wait_done(cyc, 100);
        ready_mode = 0;
        n_cmp++; if (cyc < 0) begin n_bad++; $display("FAIL bp_timeout got %0d want done", cyc); end
        n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL bp_stability got %0d violations want 0", stab_err); end
        n_cmp++; if (rx.size() !== exp.len()) begin n_bad++; $display("FAIL bp_len got %0d want %0d", rx.size(), exp.len()); end
        for (int i = 0; i < exp.len() && i < rx.size(); i++) begin
            n_cmp++; if (rx[i] !== exp[i]) begin n_bad++; $display("FAIL bp_byte%0d got %h want %h", i, rx[i], exp[i]); end
        end
    endtask

    task automatic test_abort();
        string exp1 = "cafe";
        string exp2 = "00c0ffee\n";
        int cyc, n;
        mem[9'h020] = 32'hCAFE0123;
        mem[9'h021] = 32'h11111111;
        mem[9'h033] = 32'h00C0FFEE;
        clear_mon();
        do_start(9'h020, 4);
        n = 0;
        while (rx.size() < 3 && n < 40) begin tick(); n++; end
        n_cmp++; if (rx.size() !== 3) begin n_bad++; $display("FAIL abort_wait got %0d bytes want 3", rx.size()); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++; if (tx_valid !== 1'b0 || busy !== 1'b0 || ram_re !== 1'b0) begin n_bad++; $display("FAIL abort_idle got valid=%b busy=%b re=%b want 0 0 0", tx_valid, busy, ram_re); end
        repeat (4) tick();
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_done got %0d want 0", done_cnt); end
        n_cmp++; if (rx.size() !== 4) begin n_bad++; $display("FAIL abort_len got %0d want 4", rx.size()); end
        for (int i = 0; i < exp1.len() && i < rx.size(); i++) begin
            n_cmp++; if (rx[i] !== exp1[i]) begin n_bad++; $display("FAIL abort_byte%0d got %h want %h", i, rx[i], exp1[i]); end
        end
        clear_mon();
        do_start(9'h033, 1);
        wait_done(cyc, 40);
        n_cmp++; if (cyc !== 12) begin n_bad++; $display("FAIL abort_restart_latency got %0d want 12", cyc); end
        n_cmp++; if (rd.size() !== 1 || (rd.size() > 0 && rd[0] !== 'h033)) begin n_bad++; $display("FAIL abort_restart_radr got n=%0d want one read of 033", rd.size()); end
        n_cmp++; if (rx.size() !== exp2.len()) begin n_bad++; $display("FAIL abort_restart_len got %0d want %0d", rx.size(), exp2.len()); end
        for (int i = 0; i < exp2.len() && i < rx.size(); i++) begin
            n_cmp++; if (rx[i] !== exp2[i]) begin n_bad++; $display("FAIL abort_restart_byte%0d got %h want %h", i, rx[i], exp2[i]); end
        end
    endtask

    task automatic test_reset_mid();
        string exp = "11223344\n";
        int n;
        mem[9'h040] = 32'h11223344;
        mem[9'h041] = 32'h55667788;
        mem[9'h050] = 32'hDEADBEEF;
        clear_mon();
        do_start(9'h040, 2);
        tick();
        do_start(9'h050, 1);
        n = 0;
        while (rd.size() < 2 && n < 60) begin tick(); n++; end
        n_cmp++; if (rd.size() !== 2) begin n_bad++; $display("FAIL rstmid_reads got %0d want 2", rd.size()); end
        if (rd.size() == 2) begin
            n_cmp++; if (rd[0] !== 'h040 || rd[1] !== 'h041) begin n_bad++; $display("FAIL rstmid_radr got %h,%h want 040,041", rd[0], rd[1]); end
        end
        n = 0;
        while (rx.size() < 12 && n < 40) begin tick(); n++; end
        n_cmp++; if (rx.size() < exp.len()) begin n_bad++; $display("FAIL rstmid_len got %0d want >=%0d", rx.size(), exp.len()); end
        for (int i = 0; i < exp.len() && i < rx.size(); i++) begin
            n_cmp++; if (rx[i] !== exp[i]) begin n_bad++; $display("FAIL rstmid_byte%0d got %h want %h", i, rx[i], exp[i]); end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, done, ram_re, tx_valid} !== 4'b0000) begin n_bad++; $display("FAIL rstmid_ctrl got busy=%b done=%b re=%b valid=%b want 0", busy, done, ram_re, tx_valid); end
        n_cmp++; if (tx_data !== 8'h00 || ram_radr !== '0) begin n_bad++; $display("FAIL rstmid_data got data=%h radr=%h want 00 000", tx_data, ram_radr); end
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        n_cmp++; if (done_cnt !== 0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_after got done_cnt=%0d busy=%b want 0 0", done_cnt, busy); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        test_reset();
        test_single_word();
        test_wrap();
        test_zero_count();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hexdump_streamer.md
Name: hexdump_streamer

Overview:
- Reader-side counterpart to the hex-text memory images used to preload instruction, data and systolic A/B buffers.
- On command, reads a range of words from a 1-cycle-latency 1r1w buffer RAM, e.g. the systolic result buffer.
- Streams each word out as readmemh-compatible ASCII text: 8 hex characters followed by LF.
- Byte output uses a valid/ready handshake that feeds the UART transmitter path on tx.

Parameters:
ADDR_W, 9, buffer RAM word-address width
DATA_W, 32, RAM word width; fixed at 32 (8 hex digits per word)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  1-cycle pulse; begin dump (ignored while busy)
abort  input  1  synchronous abort; returns to IDLE
base_addr  input  ADDR_W  first word address, sampled on start
word_cnt  input  ADDR_W+1  number of words to dump, sampled on start; 0 is legal
busy  output  1  high from the cycle after accepted start until return to IDLE
done  output  1  1-cycle pulse when the dump completes normally
ram_re  output  1  RAM read enable
ram_radr  output  ADDR_W  RAM read address
ram_rdata  input  DATA_W  RAM read data, valid the cycle after ram_re
tx_data  output  8  ASCII byte
tx_valid  output  1  tx_data valid
tx_ready  input  1  sink accepts the byte when tx_valid & tx_ready

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy=0, done=0, ram_re=0, ram_radr=0, tx_valid=0, tx_data=0. Internal address, count and nibble index cleared.
- FSM states: IDLE, RD_REQ, RD_WAIT, SEND_HEX, SEND_NL, FIN.
- IDLE: on start, latch addr=base_addr and remaining=word_cnt.
  - remaining==0: go to FIN.
  - otherwise: go to RD_REQ.
- RD_REQ: assert ram_re=1 with ram_radr=addr for exactly one cycle, then go to RD_WAIT.
- RD_WAIT: capture ram_rdata into a 32-bit shift register, set nibble index to 7, go to SEND_HEX.
- SEND_HEX:
  - tx_valid=1; tx_data is the ASCII code of nibble [31:28] of the shift register.
  - Encoding: 0-9 gives 0x30-0x39; a-f gives lowercase 0x61-0x66.
  - On handshake: shift left 4; after the 8th nibble go to SEND_NL.
- SEND_NL: tx_valid=1, tx_data=0x0A. On handshake:
  - addr = addr+1, modulo 2^ADDR_W (wrap from max address to 0 is legal);
  - remaining = remaining-1;
  - remaining now 0: go to FIN; otherwise go to RD_REQ.
- FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Handshake rules:
  - Once tx_valid is asserted, tx_data is held stable and tx_valid stays high until tx_ready is sampled high.
  - No bubble is required between consecutive hex characters of one word. A byte may be accepted every cycle while tx_ready=1.
  - tx_ready is ignored when tx_valid=0.
- Throughput: with tx_ready tied high, one word costs 2 (read) + 9 (bytes) = 11 cycles.
- start while busy: ignored; the latched parameters do not change.
- abort (any state except IDLE):
  - Next cycle: IDLE, tx_valid=0, ram_re=0, busy=0.
  - No done pulse.
  - A byte handshaking in the abort cycle counts as transferred.
  - abort has priority over start in the same cycle.
- Reset mid-operation: immediate return to the reset values above; no partial done.
- word_cnt = 2^ADDR_W dumps the entire RAM once, with address wrap.
- ram_rdata is sampled only in RD_WAIT; RAM changes at other times have no effect on the current word.

Test Plan:
- RAM[0x010]=0x1234ABCD, start, base=0x010, cnt=1, tx_ready=1 -> bytes 31 32 33 34 61 62 63 64 0A; exactly one ram_re with radr=0x010; done pulse one cycle after the LF handshake; 11 cycles from start to done-1.
- RAM[0x1FF]=0x00000000, RAM[0x000]=0xFFFFFFFF, base=0x1FF, cnt=2 -> "00000000\nffffffff\n"; ram_radr sequence 0x1FF then 0x000 (wrap).
- cnt=0 -> no ram_re, no tx_valid; done one cycle after the start cycle; busy high for exactly one cycle.
- tx_ready random (e.g. high 1 of 3 cycles), RAM[5]=0x9F00E001 -> tx_data/tx_valid never change while unaccepted; sink captures "9f00e001\n".
- Assert abort after 3rd byte of word 0 (cnt=4) -> next cycle tx_valid=0, busy=0, no done; a subsequent start with cnt=1 dumps correctly from new base.
- rst_n pulsed low mid-word, and a second start issued while busy -> outputs at reset values asynchronously; the second start has no effect on the byte stream or addresses.
